// File: rtl/slave_sequencer_if.sv
// Handshake bundle between the run controller and the slave sequencer.
// master drives start/abort/enables/done; slave is the sequencer side.
interface slave_sequencer_if #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2,
  parameter int TMO_W      = 8
);
  logic                  start;
  logic                  abort;
  logic [NUM_SLAVES-1:0] slave_en;
  logic [NUM_SLAVES-1:0] done;
  logic [TMO_W-1:0]      timeout_limit;
  logic [NUM_SLAVES-1:0] trigger;
  logic                  busy;
  logic [IDX_W-1:0]      cur_idx;
  logic                  seq_done;
  logic                  err;
  logic [IDX_W-1:0]      err_idx;

  modport master (
    output start, abort, slave_en, done, timeout_limit,
    input  trigger, busy, cur_idx, seq_done, err, err_idx
  );

  modport slave (
    input  start, abort, slave_en, done, timeout_limit,
    output trigger, busy, cur_idx, seq_done, err, err_idx
  );
endinterface

// File: rtl/slave_sequencer.sv
// Start/done sequencer: triggers enabled slaves one at a time in ascending order.
// Optional per-slave watchdog enabled by defining SLAVE_SEQ_TIMEOUT_EN.
module slave_sequencer #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2,
  parameter int TMO_W      = 8
) (
  input logic              clk,
  input logic              rst,
  slave_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] mask_q, mask_d;
  logic [NUM_SLAVES-1:0] trigger_q, trigger_d;
  logic                  busy_q, busy_d;
  logic                  seq_done_q, seq_done_d;
  logic [IDX_W-1:0]      cur_idx_q, cur_idx_d;
  logic                  first_found, next_found;
  logic [IDX_W-1:0]      first_idx, next_idx;
  logic                  expire;

`ifdef SLAVE_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
  assign expire  = (bus.timeout_limit != '0) && (cnt_inc >= bus.timeout_limit);
`else
  logic unused_tmo;
  assign unused_tmo = ^bus.timeout_limit;
  assign expire     = 1'b0;
`endif

  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (bus.slave_en[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (mask_q[i] && (i > 32'(cur_idx_q)) && !next_found) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    trigger_d  = trigger_q;
    busy_d     = busy_q;
    cur_idx_d  = cur_idx_q;
    seq_done_d = 1'b0;
`ifdef SLAVE_SEQ_TIMEOUT_EN
    err_d      = 1'b0;
    err_idx_d  = err_idx_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d    = 1'b0;
        trigger_d = '0;
        if (bus.start) begin
          mask_d = bus.slave_en;
          busy_d = 1'b1;
          if (!first_found) begin
            state_d = FINISH;
          end else begin
            state_d              = RUN;
            cur_idx_d            = first_idx;
            trigger_d[first_idx] = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d   = IDLE;
          trigger_d = '0;
          busy_d    = 1'b0;
        end else if (bus.done[cur_idx_q]) begin
          trigger_d = '0;
          if (next_found) begin
            cur_idx_d           = next_idx;
            trigger_d[next_idx] = 1'b1;
          end else begin
            state_d = FINISH;
          end
        end else if (expire) begin
          state_d   = IDLE;
          trigger_d = '0;
          busy_d    = 1'b0;
`ifdef SLAVE_SEQ_TIMEOUT_EN
          err_d     = 1'b1;
          err_idx_d = cur_idx_q;
`endif
        end
      end
      FINISH: begin
        state_d = IDLE;
        // busy stays up through the seq_done cycle and drops one cycle later
        if (bus.abort) begin
          busy_d = 1'b0;
        end else begin
          seq_done_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        trigger_d = '0;
        busy_d    = 1'b0;
      end
    endcase
`ifdef SLAVE_SEQ_TIMEOUT_EN
    cnt_d = (state_q == RUN && state_d == RUN && trigger_d == trigger_q) ? cnt_inc : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      trigger_q  <= '0;
      busy_q     <= 1'b0;
      cur_idx_q  <= '0;
      seq_done_q <= 1'b0;
`ifdef SLAVE_SEQ_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      trigger_q  <= trigger_d;
      busy_q     <= busy_d;
      cur_idx_q  <= cur_idx_d;
      seq_done_q <= seq_done_d;
`ifdef SLAVE_SEQ_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
`endif
    end
  end

  assign bus.trigger  = trigger_q;
  assign bus.busy     = busy_q;
  assign bus.cur_idx  = cur_idx_q;
  assign bus.seq_done = seq_done_q;
`ifdef SLAVE_SEQ_TIMEOUT_EN
  assign bus.err      = err_q;
  assign bus.err_idx  = err_idx_q;
`else
  assign bus.err      = 1'b0;
  assign bus.err_idx  = '0;
`endif
endmodule

// File: tb/tb_slave_sequencer.sv
// Self-checking bench for slave_sequencer: event scoreboard of triggers, seq_done and err.
module tb_slave_sequencer;
  localparam int N = 4;
  localparam logic [15:0] EV_TRIG = 16'd1;
  localparam logic [15:0] EV_DONE = 16'd2;
  localparam logic [15:0] EV_ERR  = 16'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  slave_sequencer_if #(.NUM_SLAVES(N), .IDX_W(2), .TMO_W(8)) bus ();

  slave_sequencer #(.NUM_SLAVES(N), .IDX_W(2), .TMO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [N-1:0] resp_done  = '0;
  logic [N-1:0] force_done = '0;
  logic [N-1:0] no_resp    = '0;
  int           age[N];
  assign bus.done = resp_done | force_done;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_obs[$];
  logic [31:0] mon_exp;
  logic [N-1:0] prev_trig = '0;

  // Slave model: each triggered slave raises done on its third trigger cycle
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.trigger[i] === 1'b1) age[i] = age[i] + 1;
      else age[i] = 0;
      resp_done[i] = (bus.trigger[i] === 1'b1) && (age[i] == 3) && !no_resp[i];
    end
  end

  always @(negedge clk) begin
    mon_obs = {};
    if (rst === 1'b0) begin
      if (bus.trigger !== prev_trig && bus.trigger !== '0)
        mon_obs.push_back({EV_TRIG, 16'(bus.trigger)});
      if (bus.seq_done === 1'b1) mon_obs.push_back({EV_DONE, 16'h0});
      if (bus.err === 1'b1) mon_obs.push_back({EV_ERR, 16'(bus.err_idx)});
    end
    prev_trig = bus.trigger;
    foreach (mon_obs[k]) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got event %h, expected none", mon_obs[k]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs[k] !== mon_exp) begin
          tests_failed++;
          $display("FAIL sb_event: got %h, expected %h", mon_obs[k], mon_exp);
        end
      end
    end
  end

  task automatic push_trig(input logic [N-1:0] t);
    exp_q.push_back({EV_TRIG, 16'(t)});
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && exp_q.size() == 0) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL %s_timeout: busy=%b pending=%0d, expected idle with 0 pending",
             name, bus.busy, exp_q.size());
  endtask

  task automatic wait_trig(input logic [N-1:0] val, input int budget, input string name);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.trigger === val) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL %s_trig_timeout: trigger=%b, expected %b", name, bus.trigger, val);
  endtask

  task automatic pulse_start(input logic [N-1:0] en);
    bus.slave_en = en;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.slave_en = '0; bus.timeout_limit = '0;
    repeat (2) @(negedge clk);
    tests_run += 6;
    if (bus.trigger !== 4'b0000) begin tests_failed++; $display("FAIL rst_trigger: got %b, expected 0000", bus.trigger); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    if (bus.cur_idx !== 2'd0) begin tests_failed++; $display("FAIL rst_cur_idx: got %0d, expected 0", bus.cur_idx); end
    if (bus.seq_done !== 1'b0) begin tests_failed++; $display("FAIL rst_seq_done: got %b, expected 0", bus.seq_done); end
    if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b, expected 0", bus.err); end
    if (bus.err_idx !== 2'd0) begin tests_failed++; $display("FAIL rst_err_idx: got %0d, expected 0", bus.err_idx); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_enabled();
    push_trig(4'b0001); push_trig(4'b0010); push_trig(4'b0100); push_trig(4'b1000);
    exp_q.push_back({EV_DONE, 16'h0});
    pulse_start(4'b1111);
    tests_run += 3;
    if (bus.trigger !== 4'b0001) begin tests_failed++; $display("FAIL t1_first_trigger: got %b, expected 0001", bus.trigger); end
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL t1_busy: got %b, expected 1", bus.busy); end
    if (bus.cur_idx !== 2'd0) begin tests_failed++; $display("FAIL t1_cur_idx: got %0d, expected 0", bus.cur_idx); end
    wait_idle(80, "t1");
    tests_run += 3;
    if (bus.trigger !== 4'b0000) begin tests_failed++; $display("FAIL t1_end_trigger: got %b, expected 0000", bus.trigger); end
    if (bus.cur_idx !== 2'd3) begin tests_failed++; $display("FAIL t1_end_cur_idx: got %0d, expected 3", bus.cur_idx); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t1_pending: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_sparse_mask();
    push_trig(4'b0010); push_trig(4'b1000);
    exp_q.push_back({EV_DONE, 16'h0});
    pulse_start(4'b1010);
    bus.slave_en = 4'b1111;
    force_done   = 4'b0101;
    tests_run += 2;
    if (bus.trigger !== 4'b0010) begin tests_failed++; $display("FAIL t2_first_trigger: got %b, expected 0010", bus.trigger); end
    if (bus.cur_idx !== 2'd1) begin tests_failed++; $display("FAIL t2_cur_idx: got %0d, expected 1", bus.cur_idx); end
    repeat (4) @(negedge clk);
    force_done = '0;
    wait_idle(80, "t2");
    tests_run += 2;
    if (bus.cur_idx !== 2'd3) begin tests_failed++; $display("FAIL t2_end_cur_idx: got %0d, expected 3", bus.cur_idx); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t2_pending: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_empty_mask();
    exp_q.push_back({EV_DONE, 16'h0});
    pulse_start(4'b0000);
    tests_run += 3;
    if (bus.seq_done !== 1'b0) begin tests_failed++; $display("FAIL t3_early_done: got %b, expected 0", bus.seq_done); end
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL t3_busy: got %b, expected 1", bus.busy); end
    if (bus.trigger !== 4'b0000) begin tests_failed++; $display("FAIL t3_trigger: got %b, expected 0000", bus.trigger); end
    @(negedge clk);
    tests_run += 2;
    if (bus.seq_done !== 1'b1) begin tests_failed++; $display("FAIL t3_done: got %b, expected 1", bus.seq_done); end
    if (bus.trigger !== 4'b0000) begin tests_failed++; $display("FAIL t3_trigger2: got %b, expected 0000", bus.trigger); end
    @(negedge clk);
    tests_run += 3;
    if (bus.seq_done !== 1'b0) begin tests_failed++; $display("FAIL t3_done_width: got %b, expected 0", bus.seq_done); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t3_busy_end: got %b, expected 0", bus.busy); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t3_pending: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    push_trig(4'b0001); push_trig(4'b0010); push_trig(4'b0100);
    no_resp = 4'b0100;
    pulse_start(4'b1111);
    wait_trig(4'b0100, 40, "t4");
    repeat (2) @(negedge clk);
    force_done = 4'b0100;
    bus.abort  = 1'b1;
    @(negedge clk);
    bus.abort  = 1'b0;
    force_done = '0;
    no_resp    = '0;
    tests_run += 4;
    if (bus.trigger !== 4'b0000) begin tests_failed++; $display("FAIL t4_trigger: got %b, expected 0000", bus.trigger); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t4_busy: got %b, expected 0", bus.busy); end
    if (bus.seq_done !== 1'b0) begin tests_failed++; $display("FAIL t4_seq_done: got %b, expected 0", bus.seq_done); end
    if (bus.cur_idx !== 2'd2) begin tests_failed++; $display("FAIL t4_cur_idx_hold: got %0d, expected 2", bus.cur_idx); end
    repeat (4) @(negedge clk);
    tests_run += 2;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t4_idle_busy: got %b, expected 0", bus.busy); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t4_pending: got %0d, expected 0", exp_q.size()); end
    // abort held alongside start in IDLE must not block the new run
    push_trig(4'b0001); push_trig(4'b0010); push_trig(4'b0100); push_trig(4'b1000);
    exp_q.push_back({EV_DONE, 16'h0});
    bus.abort = 1'b1;
    pulse_start(4'b1111);
    bus.abort = 1'b0;
    tests_run += 2;
    if (bus.trigger !== 4'b0001) begin tests_failed++; $display("FAIL t4_restart_trigger: got %b, expected 0001", bus.trigger); end
    if (bus.cur_idx !== 2'd0) begin tests_failed++; $display("FAIL t4_restart_idx: got %0d, expected 0", bus.cur_idx); end
    wait_idle(80, "t4_restart");
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t4_restart_pending: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int n;
    push_trig(4'b0001); push_trig(4'b0010);
    no_resp = 4'b0010;
    bus.timeout_limit = 8'd5;
`ifdef SLAVE_SEQ_TIMEOUT_EN
    exp_q.push_back({EV_ERR, 16'd1});
    pulse_start(4'b0011);
    wait_trig(4'b0010, 40, "t5");
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n++;
      if (bus.err === 1'b1) break;
    end
    tests_run += 4;
    if (n != 5) begin tests_failed++; $display("FAIL t5_latency: got %0d cycles, expected 5", n); end
    if (bus.err_idx !== 2'd1) begin tests_failed++; $display("FAIL t5_err_idx: got %0d, expected 1", bus.err_idx); end
    if (bus.trigger !== 4'b0000) begin tests_failed++; $display("FAIL t5_trigger: got %b, expected 0000", bus.trigger); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t5_busy: got %b, expected 0", bus.busy); end
    @(negedge clk);
    tests_run += 3;
    if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL t5_err_width: got %b, expected 0", bus.err); end
    if (bus.err_idx !== 2'd1) begin tests_failed++; $display("FAIL t5_err_idx_hold: got %0d, expected 1", bus.err_idx); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t5_idle: got %b, expected 0", bus.busy); end
`else
    n = 0;
    pulse_start(4'b0011);
    wait_trig(4'b0010, 40, "t5");
    repeat (20) @(negedge clk);
    tests_run += 4;
    if (bus.trigger !== 4'b0010) begin tests_failed++; $display("FAIL t5_wait_trigger: got %b, expected 0010", bus.trigger); end
    if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL t5_err_tied: got %b, expected 0", bus.err); end
    if (bus.err_idx !== 2'd0) begin tests_failed++; $display("FAIL t5_err_idx_tied: got %0d, expected 0", bus.err_idx); end
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL t5_still_busy: got %b, expected 1", bus.busy); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
`endif
    no_resp = '0;
    bus.timeout_limit = '0;
    repeat (2) @(negedge clk);
    tests_run += 2;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t5_end_busy: got %b, expected 0", bus.busy); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t5_pending: got %0d, expected 0 (n=%0d)", exp_q.size(), n); end
  endtask

  task automatic test_reset_midrun();
    bit seen;
    push_trig(4'b0001); push_trig(4'b0010); push_trig(4'b0100); push_trig(4'b1000);
    exp_q.push_back({EV_DONE, 16'h0});
    bus.slave_en = 4'b1111;
    bus.start    = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(negedge clk);
      if (bus.seq_done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL t6_held_start_done: got no seq_done, expected one"); end
    repeat (6) @(negedge clk);
    tests_run += 2;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t6_no_rerun: busy=%b, expected 0", bus.busy); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t6_pending: got %0d, expected 0", exp_q.size()); end

    push_trig(4'b0001); push_trig(4'b0010);
    pulse_start(4'b1111);
    wait_trig(4'b0010, 40, "t6");
    #2 rst = 1'b1;
    #1;
    tests_run += 6;
    if (bus.trigger !== 4'b0000) begin tests_failed++; $display("FAIL t6_async_trigger: got %b, expected 0000", bus.trigger); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t6_async_busy: got %b, expected 0", bus.busy); end
    if (bus.cur_idx !== 2'd0) begin tests_failed++; $display("FAIL t6_async_cur_idx: got %0d, expected 0", bus.cur_idx); end
    if (bus.seq_done !== 1'b0) begin tests_failed++; $display("FAIL t6_async_seq_done: got %b, expected 0", bus.seq_done); end
    if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL t6_async_err: got %b, expected 0", bus.err); end
    if (bus.err_idx !== 2'd0) begin tests_failed++; $display("FAIL t6_async_err_idx: got %0d, expected 0", bus.err_idx); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests_run += 3;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t6_post_busy: got %b, expected 0", bus.busy); end
    if (bus.trigger !== 4'b0000) begin tests_failed++; $display("FAIL t6_post_trigger: got %b, expected 0000", bus.trigger); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t6_post_pending: got %0d, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_all_enabled();
    test_sparse_mask();
    test_empty_mask();
    test_abort();
    test_timeout();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
